// File: rtl/ddr3_traffic_checker.sv
// Purpose : BIST traffic generator/checker for the ddr3_core mem_* port: writes a seeded pattern, reads it back, compares.
// Latency : one request in flight; each word costs REQ (>=1 cycle) + ACK (>=1 cycle); done_o pulses one cycle after the last ack.
// Backpr. : request strobes and addr/data/id held stable until mem_accept_i; per-state timeout aborts a stalled run.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   start_i               run trigger, honoured only in IDLE
//   mode_i                0/3 write+verify, 1 write-only, 2 verify-only
//   base_addr_i, count_i  first byte address (aligned down to a word), number of words
//   seed_i                pattern seed
//   busy_o, done_o        run in progress, one-cycle end-of-run pulse
//   pass_o, timeout_o     run result (valid from done until next start), sticky timeout flag
//   err_count_o           saturating count of failing acks
//   first_err_addr_o      address of the first failing ack
//   mem_*                 request/response interface towards ddr3_core
module ddr3_traffic_checker #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]    count_i,
    input  logic [31:0]         seed_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    err_count_o,
    output logic [ADDR_W-1:0]   first_err_addr_o,
    output logic [DATA_W/8-1:0] mem_wr_o,
    output logic                mem_rd_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_write_data_o,
    output logic [ID_W-1:0]     mem_req_id_o,
    input  logic                mem_accept_i,
    input  logic                mem_ack_i,
    input  logic                mem_error_i,
    input  logic [ID_W-1:0]     mem_resp_id_i,
    input  logic [DATA_W-1:0]   mem_read_data_i
);

    localparam int LANES = DATA_W / 32;
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_ACK,
        S_RD_REQ,
        S_RD_ACK,
        S_DONE
    } state_t;

    state_t             state;
    logic               do_rd_q;
    logic [31:0]        seed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  base_q;
    logic [ID_W-1:0]    id_ctr;
    logic [TMR_W-1:0]   tmr;

    // Lane j of word idx: seed ^ ((idx << 8) | j)
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] seed,
                                                  input logic [CNT_W-1:0] idx);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int j = 0; j < LANES; j++) begin
            p[32*j +: 32] = seed ^ ((32'(idx) << 8) | 32'(8'(j)));
        end
        return p;
    endfunction

    logic [ADDR_W-1:0]  base_al;
    logic               last_word;
    logic [CNT_W-1:0]   idx_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [DATA_W-1:0]  exp_data;
    logic               rd_bad;
    logic               ack_err;
    logic [CNT_W-1:0]   err_cnt_nxt;
    logic               tmo_hit;

    always_comb begin
        base_al     = {base_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        last_word   = (idx_q == cnt_q - CNT_W'(1));
        idx_nxt     = idx_q + CNT_W'(1);
        addr_nxt    = mem_addr_o + ADDR_W'(BYTES);
        id_nxt      = id_ctr + ID_W'(1);
        exp_data    = pattern(seed_q, idx_q);
        // The issued id stays on mem_req_id_o after accept, so it doubles as the expected response id.
        rd_bad      = mem_error_i | (mem_read_data_i != exp_data) | (mem_resp_id_i != mem_req_id_o);
        ack_err     = (state == S_WR_ACK) ? mem_error_i : rd_bad;
        err_cnt_nxt = (ack_err && (err_count_o != '1)) ? err_count_o + CNT_W'(1) : err_count_o;
        // Timer restarts on every state entry; an accept/ack in the final cycle still wins.
        tmo_hit     = (TIMEOUT != 0) && (tmr == TMR_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            mem_wr_o         <= '0;
            mem_rd_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_write_data_o <= '0;
            mem_req_id_o     <= '0;
            do_rd_q          <= 1'b0;
            seed_q           <= '0;
            cnt_q            <= '0;
            idx_q            <= '0;
            base_q           <= '0;
            id_ctr           <= '0;
            tmr              <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        do_rd_q          <= (mode_i != 2'd1);
                        seed_q           <= seed_i;
                        cnt_q            <= count_i;
                        base_q           <= base_al;
                        idx_q            <= '0;
                        tmr              <= '0;
                        err_count_o      <= '0;
                        first_err_addr_o <= '0;
                        timeout_o        <= 1'b0;
                        pass_o           <= 1'b0;
                        busy_o           <= 1'b1;
                        if (count_i == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                            pass_o <= 1'b1;
                        end else begin
                            mem_addr_o   <= base_al;
                            mem_req_id_o <= id_nxt;
                            id_ctr       <= id_nxt;
                            if (mode_i == 2'd2) begin
                                mem_rd_o <= 1'b1;
                                state    <= S_RD_REQ;
                            end else begin
                                mem_wr_o         <= '1;
                                mem_write_data_o <= pattern(seed_i, '0);
                                state            <= S_WR_REQ;
                            end
                        end
                    end
                end

                S_WR_REQ, S_RD_REQ: begin
                    if (mem_accept_i) begin
                        mem_wr_o <= '0;
                        mem_rd_o <= 1'b0;
                        tmr      <= '0;
                        state    <= (state == S_WR_REQ) ? S_WR_ACK : S_RD_ACK;
                    end else if (tmo_hit) begin
                        mem_wr_o  <= '0;
                        mem_rd_o  <= 1'b0;
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_WR_ACK, S_RD_ACK: begin
                    if (mem_ack_i) begin
                        err_count_o <= err_cnt_nxt;
                        if (ack_err && (err_count_o == '0)) begin
                            first_err_addr_o <= mem_addr_o;
                        end
                        tmr <= '0;
                        if (!last_word) begin
                            idx_q        <= idx_nxt;
                            mem_addr_o   <= addr_nxt;
                            mem_req_id_o <= id_nxt;
                            id_ctr       <= id_nxt;
                            if (state == S_WR_ACK) begin
                                mem_wr_o         <= '1;
                                mem_write_data_o <= pattern(seed_q, idx_nxt);
                                state            <= S_WR_REQ;
                            end else begin
                                mem_rd_o <= 1'b1;
                                state    <= S_RD_REQ;
                            end
                        end else if ((state == S_WR_ACK) && do_rd_q) begin
                            // Write phase complete: restart the walk at the base for verification.
                            idx_q        <= '0;
                            mem_addr_o   <= base_q;
                            mem_req_id_o <= id_nxt;
                            id_ctr       <= id_nxt;
                            mem_rd_o     <= 1'b1;
                            state        <= S_RD_REQ;
                        end else begin
                            // pass_o must see the error from this final ack, hence err_cnt_nxt.
                            pass_o <= (err_cnt_nxt == '0);
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else if (tmo_hit) begin
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_DONE: begin
                    // start_i is deliberately not looked at here.
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Purpose : randomized scoreboard bench for ddr3_traffic_checker against a behavioural memory and reference model.
// Latency : memory responder applies configurable accept delay and ack latency; results checked at done_o.
// Backpr. : accept is withheld for a configurable number of cycles to exercise request holding.
module tb_ddr3_traffic_checker;

    localparam int DATA_W  = 128;
    localparam int ADDR_W  = 32;
    localparam int ID_W    = 16;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1023;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start_i = 1'b0;
    logic [1:0]         mode_i = '0;
    logic [ADDR_W-1:0]  base_addr_i = '0;
    logic [CNT_W-1:0]   count_i = '0;
    logic [31:0]        seed_i = '0;
    logic               busy_o, done_o, pass_o, timeout_o;
    logic [CNT_W-1:0]   err_count_o;
    logic [ADDR_W-1:0]  first_err_addr_o;
    logic [15:0]        mem_wr_o;
    logic               mem_rd_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [DATA_W-1:0]  mem_write_data_o;
    logic [ID_W-1:0]    mem_req_id_o;
    logic               mem_accept_i = 1'b0;
    logic               mem_ack_i = 1'b0;
    logic               mem_error_i = 1'b0;
    logic [ID_W-1:0]    mem_resp_id_i = '0;
    logic [DATA_W-1:0]  mem_read_data_i = '0;

    ddr3_traffic_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .count_i(count_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_write_data_o(mem_write_data_o), .mem_req_id_o(mem_req_id_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_resp_id_i(mem_resp_id_i), .mem_read_data_i(mem_read_data_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit           rd;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  id;
        int           hold;
    } req_t;

    typedef struct {
        bit           pass;
        int           errs;
        logic [31:0]  first;
        bit           tmo;
        int           start_lat;
        int           tmo_lat;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    logic [15:0] exp_id = '0;
    int start_cyc = 0;

    // Memory behaviour knobs
    int          acc_min = 0, acc_max = 0, ack_max = 0;
    bit          no_ack = 0;
    bit          flip_en = 0;
    logic [31:0] flip_addr = '0;
    bit          errinj_en = 0;
    logic [31:0] errinj_addr = '0;

    logic [127:0] ram [logic [31:0]];
    logic [127:0] ref_mem [logic [31:0]];

    function automatic logic [127:0] ref_pat(input logic [31:0] seed, input int i);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[32*j +: 32] = seed ^ 32'((i % 65536) * 256 + j);
        return v;
    endfunction

    // Memory responder
    int          r_wait = 0, r_tgt = 0, r_lat = 0;
    bit          r_pend = 0, r_rd = 0;
    logic [31:0] r_addr;
    logic [15:0] r_id;
    always @(negedge clock) begin
        mem_accept_i    = 1'b0;
        mem_ack_i       = 1'b0;
        mem_error_i     = 1'b0;
        mem_resp_id_i   = '0;
        mem_read_data_i = '0;
        if (reset) begin
            r_pend = 0;
            r_wait = 0;
        end else if (r_pend) begin
            if (r_lat == 0) begin
                r_pend = 0;
                if (!no_ack) begin
                    mem_ack_i     = 1'b1;
                    mem_resp_id_i = r_id;
                    mem_error_i   = errinj_en && (r_addr == errinj_addr);
                    if (r_rd) begin
                        mem_read_data_i = ram.exists(r_addr) ? ram[r_addr] : '0;
                        if (flip_en && r_addr == flip_addr) mem_read_data_i[5] = ~mem_read_data_i[5];
                    end
                end
            end else begin
                r_lat--;
            end
        end else if (mem_wr_o != '0 || mem_rd_o) begin
            if (r_wait == 0) r_tgt = $urandom_range(acc_max, acc_min);
            r_wait++;
            if (r_wait > r_tgt) begin
                mem_accept_i = 1'b1;
                r_wait = 0;
                r_pend = 1;
                r_lat  = $urandom_range(ack_max, 0);
                r_rd   = mem_rd_o;
                r_addr = mem_addr_o;
                r_id   = mem_req_id_o;
                if (mem_wr_o != '0) ram[mem_addr_o] = mem_write_data_o;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a request or a done pulse
    bit           m_active = 0, m_stable = 0;
    int           m_len = 0, m_hold = 0, m_end_cyc = 0;
    logic [31:0]  m_addr;
    logic [127:0] m_data;
    logic [15:0]  m_id;
    always @(negedge clock) begin
        req_t e;
        res_t r;
        if (reset) begin
            m_active = 0;
        end else begin
            if ((mem_wr_o != '0 || mem_rd_o) && !m_active) begin
                m_active = 1; m_len = 1; m_stable = 1;
                m_addr = mem_addr_o; m_data = mem_write_data_o; m_id = mem_req_id_o;
                if (exp_req.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_req: addr %0h id %0h with nothing expected", mem_addr_o, mem_req_id_o);
                    m_hold = 0;
                end else begin
                    e = exp_req.pop_front();
                    m_hold = e.hold;
                    check("req_kind", {mem_wr_o, mem_rd_o}, e.rd ? {16'h0000, 1'b1} : {16'hFFFF, 1'b0});
                    check("req_addr", mem_addr_o, e.addr);
                    check("req_id", mem_req_id_o, e.id);
                    if (!e.rd) check("req_wdata", mem_write_data_o, e.data);
                end
            end else if ((mem_wr_o != '0 || mem_rd_o) && m_active) begin
                m_len++;
                if (mem_addr_o !== m_addr || mem_write_data_o !== m_data || mem_req_id_o !== m_id) m_stable = 0;
            end else if (m_active) begin
                m_active = 0;
                m_end_cyc = cyc;
                check("req_stable", m_stable, 1);
                if (m_hold > 0) check("req_hold_len", m_len, m_hold);
            end
            if (done_o) begin
                if (exp_res.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_done: done pulse with no run expected");
                end else begin
                    r = exp_res.pop_front();
                    check("pass", pass_o, r.pass);
                    check("err_count", err_count_o, r.errs);
                    check("first_err_addr", first_err_addr_o, r.first);
                    check("timeout", timeout_o, r.tmo);
                    if (r.start_lat >= 0) check("done_latency", cyc - start_cyc, r.start_lat);
                    if (r.tmo_lat >= 0) check("timeout_cycles", cyc - m_end_cyc, r.tmo_lat);
                end
            end
        end
    end

    // Reference model plus start pulse
    task automatic launch(input int mode, input logic [31:0] base, input int count,
                          input logic [31:0] seed, input bit stray);
        req_t q;
        res_t r;
        logic [31:0]  al, a, first;
        logic [127:0] rdv;
        int errs, hold;
        bit wr_ph, rd_ph, stop;
        al = base & 32'hFFFF_FFF0;
        errs = 0; first = '0; stop = 0;
        hold = (acc_min == acc_max) ? acc_min + 1 : 0;
        wr_ph = (mode != 2);
        rd_ph = (mode != 1);
        r.tmo = 0; r.start_lat = -1; r.tmo_lat = -1;
        if (count == 0) begin
            r.start_lat = 1;
        end else begin
            if (wr_ph) begin
                for (int i = 0; i < count && !stop; i++) begin
                    a = al + i * 16;
                    exp_id++;
                    q.rd = 0; q.addr = a; q.data = ref_pat(seed, i); q.id = exp_id; q.hold = hold;
                    exp_req.push_back(q);
                    ref_mem[a] = q.data;
                    if (no_ack) begin
                        stop = 1; r.tmo = 1; r.tmo_lat = TIMEOUT;
                    end else if (errinj_en && a == errinj_addr) begin
                        if (errs == 0) first = a;
                        errs++;
                    end
                end
            end
            if (rd_ph && !stop) begin
                for (int i = 0; i < count; i++) begin
                    a = al + i * 16;
                    exp_id++;
                    q.rd = 1; q.addr = a; q.data = '0; q.id = exp_id; q.hold = hold;
                    exp_req.push_back(q);
                    rdv = ref_mem.exists(a) ? ref_mem[a] : '0;
                    if (flip_en && a == flip_addr) rdv[5] = ~rdv[5];
                    if (rdv != ref_pat(seed, i) || (errinj_en && a == errinj_addr)) begin
                        if (errs == 0) first = a;
                        errs++;
                    end
                end
            end
        end
        r.errs = errs; r.first = first; r.pass = (errs == 0) && !r.tmo;
        exp_res.push_back(r);

        @(negedge clock);
        mode_i = 2'(mode); base_addr_i = base; count_i = 16'(count); seed_i = seed;
        start_i = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        if (stray && count > 0) begin
            start_i = 1'b1; mode_i = 2'd1; count_i = 16'(count + 3); seed_i = ~seed;
            @(negedge clock);
            start_i = 1'b0;
        end
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_res.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_req.size() != 0 || exp_res.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL run_budget: %0d requests and %0d results pending after %0d cycles",
                     exp_req.size(), exp_res.size(), budget);
            exp_req.delete();
            exp_res.delete();
        end
        repeat (2) @(negedge clock);
        check("busy_after_done", busy_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_outputs", {busy_o, done_o, pass_o, timeout_o, err_count_o, first_err_addr_o,
                                mem_wr_o, mem_rd_o, mem_addr_o, mem_req_id_o}, '0);
        check("reset_wdata", mem_write_data_o, '0);
        exp_req.delete();
        exp_res.delete();
        exp_id = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mode, cnt, k;
        logic [31:0] base;
        bit seen;

        // Reset state and basic write+verify
        do_reset();
        launch(0, 32'h0, 3, 32'h0, 0);
        wait_run(500);

        // Corrupted read of word at address 16
        flip_en = 1; flip_addr = 32'h10;
        launch(0, 32'h0, 3, 32'h0, 0);
        wait_run(500);
        flip_en = 0;

        // Accept held off 7 cycles per request, ids from a fresh reset
        do_reset();
        acc_min = 7; acc_max = 7;
        launch(0, 32'h0, 3, 32'h1234_5678, 1);
        wait_run(500);
        acc_min = 0; acc_max = 0;

        // Memory never acks
        no_ack = 1;
        launch(0, 32'h200, 2, 32'hCAFE_0000, 0);
        wait_run(3000);
        no_ack = 0;
        repeat (3) @(negedge clock);

        // Address wrap and empty run
        launch(0, 32'hFFFF_FFF0, 2, 32'hA5A5_0001, 0);
        wait_run(500);
        launch(0, 32'h40, 0, 32'h1, 0);
        wait_run(50);

        // Reset mid read phase, then a clean rerun
        acc_max = 2; ack_max = 2;
        launch(0, 32'h300, 4, 32'h0BAD_F00D, 0);
        seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clock);
            if (mem_rd_o) seen = 1;
        end
        check("read_phase_reached", seen, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_outputs", {busy_o, done_o, pass_o, timeout_o, err_count_o, first_err_addr_o,
                                       mem_wr_o, mem_rd_o, mem_addr_o, mem_req_id_o}, '0);
        exp_req.delete();
        exp_res.delete();
        exp_id = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        launch(0, 32'h300, 4, 32'h0BAD_F00D, 0);
        wait_run(500);

        // Randomized runs
        acc_max = 3; ack_max = 3;
        for (int t = 0; t < 10; t++) begin
            mode = $urandom_range(3, 0);
            cnt  = $urandom_range(6, 1);
            base = $urandom;
            k    = $urandom_range(cnt - 1, 0);
            errinj_en   = ($urandom_range(2, 0) == 0);
            errinj_addr = (base & 32'hFFFF_FFF0) + k * 16;
            launch(mode, base, cnt, $urandom, (t % 2) == 1);
            wait_run(1000);
        end
        errinj_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
